// File: rtl/quadrature_decoder_pkg.sv
// Shared quadrature phase constants and the edge classifier used by the decoder.
package quadrature_decoder_pkg;

  localparam logic [1:0] QUAD_S00 = 2'b00;
  localparam logic [1:0] QUAD_S01 = 2'b01;
  localparam logic [1:0] QUAD_S11 = 2'b11;
  localparam logic [1:0] QUAD_S10 = 2'b10;

  // delta is +1 / 0 / -1 along the Gray sequence; illegal marks a two-bit jump
  typedef struct packed {
    logic signed [1:0] delta;
    logic              illegal;
  } quad_step_t;

  // Position of a phase within the 00->01->11->10 cycle
  function automatic logic [1:0] quad_phase(input logic [1:0] s);
    logic [1:0] idx;
    case (s)
      QUAD_S00: idx = 2'd0;
      QUAD_S01: idx = 2'd1;
      QUAD_S11: idx = 2'd2;
      QUAD_S10: idx = 2'd3;
      default:  idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Classify the move from prev_state to cur_state; the 2-bit phase difference
  // wraps naturally, so 1 is forward, 3 is backward and 2 is a skipped phase.
  function automatic quad_step_t quad_delta(input logic [1:0] prev_state,
                                            input logic [1:0] cur_state);
    quad_step_t res;
    logic [1:0] diff;
    diff        = quad_phase(cur_state) - quad_phase(prev_state);
    res.delta   = 2'sb00;
    res.illegal = 1'b0;
    case (diff)
      2'd1:    res.delta   = 2'sb01;
      2'd3:    res.delta   = 2'sb11;
      2'd2:    res.illegal = 1'b1;
      default: res.delta   = 2'sb00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quadrature_decoder_input_debounce.sv
// Two-flop synchroniser followed by a stability counter for one encoder pin.
// After reset the first synchronised sample is adopted directly (ready rises),
// so a pin resting high is not mistaken for a fresh transition.
module input_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic ready
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic          ready_r;
  logic [1:0]    fill_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw pin, acquire the resting level, then debounce changes
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      ready_r <= 1'b0;
      fill_r  <= 2'd0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (!ready_r) begin
        cnt_r <= '0;
        if (fill_r == 2'd2) begin
          deb_r   <= sync2_r;
          ready_r <= 1'b1;
        end else begin
          fill_r <= fill_r + 2'd1;
        end
      end else if (sync2_r == deb_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        deb_r <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign dout  = deb_r;
  assign ready = ready_r;

endmodule

// File: rtl/quadrature_decoder.sv
// Rotary encoder front end: debounced A/B, quadrature tracking, detent division
// into a wrapping 2-bit position code, and illegal-transition flagging.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [1:0] encoder_value,
  output logic       step,
  output logic       dir,
  output logic       error
);

  localparam logic signed [2:0] SUB_MAX = 3'(STEPS_PER_DETENT - 1);
  localparam logic signed [2:0] SUB_MIN = -SUB_MAX;

  logic              a_deb_s;
  logic              b_deb_s;
  logic              a_ready_s;
  logic              b_ready_s;
  logic [1:0]        cur_s;
  quad_step_t        q_s;

  logic              primed_r, primed_s;
  logic [1:0]        prev_r, prev_s;
  logic signed [2:0] sub_r, sub_s;
  logic [1:0]        value_r, value_s;
  logic              step_r, step_s;
  logic              dir_r, dir_s;
  logic              error_r, error_s;

  input_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .din   (enc_a),
    .dout  (a_deb_s),
    .ready (a_ready_s)
  );

  input_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .din   (enc_b),
    .dout  (b_deb_s),
    .ready (b_ready_s)
  );

  assign cur_s = {a_deb_s, b_deb_s};

  // Next-state: prime on the first valid sample, then track edges and detents
  always_comb begin
    q_s      = quad_delta(prev_r, cur_s);
    primed_s = primed_r;
    prev_s   = prev_r;
    sub_s    = sub_r;
    value_s  = value_r;
    step_s   = 1'b0;
    dir_s    = dir_r;
    error_s  = 1'b0;
    if (!primed_r) begin
      if (a_ready_s && b_ready_s) begin
        primed_s = 1'b1;
        prev_s   = cur_s;
      end else begin
        prev_s   = prev_r;
      end
    end else begin
      prev_s = cur_s;
      if (q_s.illegal) begin
        error_s = 1'b1;
      end else if (q_s.delta == 2'sb01) begin
        if (sub_r == SUB_MAX) begin
          value_s = value_r + 2'd1;
          step_s  = 1'b1;
          dir_s   = 1'b1;
          sub_s   = 3'sd0;
        end else begin
          sub_s   = sub_r + 3'sd1;
        end
      end else if (q_s.delta == 2'sb11) begin
        if (sub_r == SUB_MIN) begin
          value_s = value_r - 2'd1;
          step_s  = 1'b1;
          dir_s   = 1'b0;
          sub_s   = 3'sd0;
        end else begin
          sub_s   = sub_r - 3'sd1;
        end
      end else begin
        sub_s = sub_r;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      primed_r <= 1'b0;
      prev_r   <= 2'b00;
      sub_r    <= 3'sd0;
      value_r  <= 2'b00;
      step_r   <= 1'b0;
      dir_r    <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      primed_r <= primed_s;
      prev_r   <= prev_s;
      sub_r    <= sub_s;
      value_r  <= value_s;
      step_r   <= step_s;
      dir_r    <= dir_s;
      error_r  <= error_s;
    end
  end

  assign encoder_value = value_r;
  assign step          = step_r;
  assign dir           = dir_r;
  assign error         = error_r;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with a step/error scoreboard.
module tb_quadrature_decoder;

  localparam int DEB = 4;
  localparam int S   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic [1:0] encoder_value;
  logic       step;
  logic       dir;
  logic       error;

  typedef struct packed {
    logic [1:0] val;
    logic       dir;
  } step_exp_t;

  step_exp_t  step_q[$];
  logic [1:0] err_q[$];

  int         checks = 0;
  int         errors = 0;

  // bench model of the decoder position
  logic [1:0] tb_prev;
  int         tb_sub;
  logic [1:0] tb_val;

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] seq3 [11] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01,
                            2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};

  quadrature_decoder #(.DEBOUNCE_CYCLES(DEB), .STEPS_PER_DETENT(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
    .encoder_value (encoder_value),
    .step          (step),
    .dir           (dir),
    .error         (error)
  );

  always #5 clk = ~clk;

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set the pins, update the model, push expectations, hold for some cycles
  task automatic drive(input logic a, input logic b, input int hold);
    logic [1:0] cur;
    int d;
    cur   = {a, b};
    enc_a = a;
    enc_b = b;
    d = (gidx(cur) - gidx(tb_prev) + 4) % 4;
    if (d == 1) begin
      if (tb_sub == S - 1) begin
        tb_val = tb_val + 2'd1;
        tb_sub = 0;
        step_q.push_back('{val: tb_val, dir: 1'b1});
      end else begin
        tb_sub++;
      end
    end else if (d == 3) begin
      if (tb_sub == -(S - 1)) begin
        tb_val = tb_val - 2'd1;
        tb_sub = 0;
        step_q.push_back('{val: tb_val, dir: 1'b0});
      end else begin
        tb_sub--;
      end
    end else if (d == 2) begin
      err_q.push_back(tb_val);
    end
    tb_prev = cur;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
  endtask

  task automatic cw_detent(input int hold);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] nx;
      nx = gray[(gidx(tb_prev) + 1) % 4];
      drive(nx[1], nx[0], hold);
    end
  endtask

  task automatic ccw_detent(input int hold);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] nx;
      nx = gray[(gidx(tb_prev) + 3) % 4];
      drive(nx[1], nx[0], hold);
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {3'b000, encoder_value, step, dir, error}, 8'h00);
    reset   = 1'b0;
    tb_prev = {a, b};
    tb_sub  = 0;
    tb_val  = 2'b00;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    tb_prev = 2'b00;
    tb_sub  = 0;
    tb_val  = 2'b00;

    // scoreboard monitor: every step/error must match a queued expectation
    fork
      begin
        logic [1:0] prev_val;
        prev_val = 2'b00;
        forever begin
          @(negedge clk);
          if (reset) begin
            prev_val = 2'b00;
          end else begin
            check("step_vs_change", {7'd0, step}, {7'd0, encoder_value != prev_val});
            if (step) begin
              check("step_expected", {7'd0, step_q.size() != 0}, 8'h01);
              if (step_q.size() != 0) begin
                step_exp_t e;
                e = step_q.pop_front();
                check("step_value", {6'd0, encoder_value}, {6'd0, e.val});
                check("step_dir", {7'd0, dir}, {7'd0, e.dir});
              end
            end
            if (error) begin
              check("error_expected", {7'd0, err_q.size() != 0}, 8'h01);
              if (err_q.size() != 0) begin
                logic [1:0] ev;
                ev = err_q.pop_front();
                check("error_value_hold", {6'd0, encoder_value}, {6'd0, ev});
              end
            end
            prev_val = encoder_value;
          end
        end
      end
    join_none

    // 1: reset with both pins high, then quiet
    @(posedge clk);
    #1;
    do_reset(1'b1, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("t1_value", {6'd0, encoder_value}, 8'h00);

    // 2: one CW detent, step exactly 7 cycles after the last pin change
    do_reset(1'b0, 1'b0);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t2_step_early", {5'd0, encoder_value, step}, {5'd0, 2'b00, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("t2_step_on_time", {4'd0, encoder_value, step, dir}, {4'd0, 2'b01, 1'b1, 1'b1});
    @(posedge clk);
    #1;

    // 3: five CW detents then six CCW with wrapping values
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i < 5) cw_detent(10);
      else       ccw_detent(10);
      check("t3_value", {6'd0, encoder_value}, {6'd0, seq3[i]});
    end
    check("t3_dir_ccw", {7'd0, dir}, 8'h00);

    // 4: 3-cycle glitch on A is dropped; 4-cycle stable changes are accepted
    do_reset(1'b0, 1'b0);
    enc_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    enc_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t4_glitch_value", {6'd0, encoder_value}, 8'h00);
    cw_detent(4);
    repeat (10) @(posedge clk);
    #1;
    check("t4_short_hold_step", {6'd0, encoder_value}, 8'h01);

    // 5: illegal 00->11, then one valid CW detent
    do_reset(1'b0, 1'b0);
    drive(1'b1, 1'b1, 12);
    check("t5_error_seen", {7'd0, err_q.size() == 0}, 8'h01);
    check("t5_value_held", {6'd0, encoder_value}, 8'h00);
    cw_detent(10);
    check("t5_after_detent", {6'd0, encoder_value}, 8'h01);

    // 6: half detent and back, then reset at sub-count +2
    do_reset(1'b0, 1'b0);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    check("t6_half_back", {6'd0, encoder_value}, 8'h00);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    do_reset(1'b1, 1'b1);
    cw_detent(10);
    check("t6_after_reset", {6'd0, encoder_value}, 8'h01);

    repeat (20) @(posedge clk);
    #1;
    check("final_step_q_empty", step_q.size(), 8'h00);
    check("final_err_q_empty", err_q.size(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
